vga_sync_receiver: RTL and testbench

- Receive end of the VGA timing interface: consumes the hsync/vsync pair produced by the timing generator and recovers the pixel position (x, y), active-video flag and frame-start strobe.
- Tracks lock with a small FSM and counts timing violations.
- Used as an on-chip timing checker and as the front end for blocks that only see sync signals.
- Default timing: 640x480 @ 800x525 totals.

---
 rtl/vga_sync_receiver.sv | 146 ++++++++++++++
 tb/tb_vga_sync_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync receiver: recovers x/y position, active video and lock from hsync/vsync
module vga_sync_receiver #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_TOTAL    = 525,
  parameter int SYNC_POL   = 0,
  parameter int MISS_LIMIT = 4
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);

  // Counters are 10 bits wide, so the frame totals must fit in that range.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_size
    $error("vga_sync_receiver: H_TOTAL and V_TOTAL must be <= 1024");
  end

  localparam int        MW       = $clog2(MISS_LIMIT + 1);
  localparam logic      POL      = 1'(SYNC_POL);
  localparam logic [9:0] H_SS_C   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] V_SS_C   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [MW-1:0] MISS_TOP = MW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_H_LOCK,
    ST_LOCKED
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [MW-1:0] miss_cnt;
  logic [MW-1:0] miss_nxt;
  logic          hs_prev;
  logic          vs_prev;
  logic          hs_edge;
  logic          vs_edge;
  logic [9:0]    h_next;
  logic [9:0]    v_next;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic          h_wrap;
  logic          checking;
  logic          h_bad;
  logic          v_bad;
  logic          any_bad;
  logic          lock_nxt;

  // Sync edges: asserted now, deasserted on the previous sample.
  assign hs_edge = (hsync == POL) && (hs_prev != POL);
  assign vs_edge = (vsync == POL) && (vs_prev != POL);

  assign h_next = (x == H_LAST) ? 10'd0 : x + 10'd1;
  assign v_next = (y == V_LAST) ? 10'd0 : y + 10'd1;

  // Next position, timing checks and lock state transitions.
  always_comb begin
    x_nxt     = hs_edge ? H_SS_C : h_next;
    h_wrap    = !hs_edge && (x == H_LAST);
    y_nxt     = y;
    if (h_wrap) begin
      y_nxt = v_next;
    end
    if (vs_edge) begin
      y_nxt = V_SS_C;
    end

    checking  = (state != ST_SEARCH);
    h_bad     = checking && (hs_edge ? (h_next != H_SS_C) : (h_next == H_SS_C));
    v_bad     = (state == ST_LOCKED) && vs_edge && (v_next != V_SS_C);
    any_bad   = h_bad || v_bad;

    state_nxt = state;
    miss_nxt  = miss_cnt;
    case (state)
      ST_SEARCH: if (hs_edge) state_nxt = ST_H_LOCK;
      ST_H_LOCK: if (vs_edge) state_nxt = ST_LOCKED;
      ST_LOCKED: if (v_bad)   state_nxt = ST_H_LOCK;
      default:                state_nxt = ST_SEARCH;
    endcase

    // Losing horizontal lock overrides any vertical transition this cycle.
    if (checking) begin
      if (h_bad) begin
        if (miss_cnt >= MISS_TOP) begin
          miss_nxt  = '0;
          state_nxt = ST_SEARCH;
        end else begin
          miss_nxt = MW'(miss_cnt + 1'b1);
        end
      end else if (hs_edge) begin
        miss_nxt = '0;
      end
    end

    lock_nxt = (state_nxt == ST_LOCKED);
  end

  // Register counters, FSM state and all outputs from their next-state values.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SEARCH;
      miss_cnt    <= '0;
      hs_prev     <= ~POL;
      vs_prev     <= ~POL;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      miss_cnt    <= miss_nxt;
      hs_prev     <= hsync;
      vs_prev     <= vsync;
      x           <= x_nxt;
      y           <= y_nxt;
      locked      <= lock_nxt;
      active      <= lock_nxt && (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
      frame_start <= lock_nxt && (x_nxt == 10'd0) && (y_nxt == 10'd0);
      err         <= any_bad;
      if (any_bad && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed self-checking bench for vga_sync_receiver
module tb_vga_sync_receiver;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HT = 24;
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VT = 10;
  localparam int HSS = HA + HF;   // 18
  localparam int VSS = VA + VF;   // 8
  localparam int HW = 3;          // hsync pulse width

  logic       pixel_clk;
  logic       reset_n;
  logic       hsync;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       frame_start;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  int checks;
  int errors;
  int gx, gy;
  int supp_n, early_n, vbad;
  int err_pulses, act_cnt, fs_cnt;
  int fs_x, fs_y;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VF), .V_TOTAL(VT),
    .SYNC_POL(0), .MISS_LIMIT(4)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset_n(reset_n),
    .hsync(hsync),
    .vsync(vsync),
    .x(x),
    .y(y),
    .active(active),
    .frame_start(frame_start),
    .locked(locked),
    .err(err),
    .err_count(err_count)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal active-low generator at (gx,gy) with optional faults.
  task automatic drive();
    int hs_start;
    logic hs_on, vs_on;
    hs_start = (early_n > 0) ? HSS - 3 : HSS;
    hs_on = (gx >= hs_start) && (gx < hs_start + HW) && (supp_n == 0);
    vs_on = (gy == VSS) || ((vbad != 0) && (gy == 4));
    hsync = hs_on ? 1'b0 : 1'b1;
    vsync = vs_on ? 1'b0 : 1'b1;
  endtask

  task automatic cyc();
    @(posedge pixel_clk);
    #1;
    err_pulses += int'(err);
    act_cnt    += int'(active);
    if (frame_start) begin
      fs_cnt++;
      fs_x = int'(x);
      fs_y = int'(y);
    end
    gx = gx + 1;
    if (gx == HT) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end
    if (gx == HSS + HW) begin
      if (supp_n > 0)  supp_n--;
      if (early_n > 0) early_n--;
    end
    drive();
  endtask

  task automatic cyc_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_gen(input int tx, input int ty);
    int n;
    n = 0;
    while (!((gx == tx) && (gy == ty)) && (n < 500)) begin
      cyc();
      n++;
    end
    chk("wait_gen_reached", ((gx == tx) && (gy == ty)) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0;
    gx = 0; gy = 0; supp_n = 0; early_n = 0; vbad = 0;
    err_pulses = 0; act_cnt = 0; fs_cnt = 0; fs_x = -1; fs_y = -1;
    reset_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;

    // Reset state
    @(posedge pixel_clk); @(posedge pixel_clk); #1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_locked", locked, 0);
    chk("rst_active", active, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);

    // Release with idle syncs: x free-runs
    reset_n = 1'b1;
    @(posedge pixel_clk); #1;
    chk("free_x1", x, 1);
    @(posedge pixel_clk); #1;
    chk("free_x2", x, 2);
    chk("free_locked", locked, 0);

    // Acquisition from an ideal generator starting at (0,0)
    gx = 0; gy = 0; drive();
    err_pulses = 0;
    cyc_n(18);
    cyc();
    chk("acq_x_after_hsync", x, HSS);
    chk("acq_locked_before_v", locked, 0);
    wait_gen(0, VSS);
    chk("acq_locked_at_v_drive", locked, 0);
    cyc();
    chk("acq_y_after_vsync", y, VSS);
    chk("acq_x_after_vsync", x, 0);
    chk("acq_locked", locked, 1);
    chk("acq_no_err_pulses", err_pulses, 0);

    // One full frame while locked
    act_cnt = 0; fs_cnt = 0; err_pulses = 0;
    cyc_n(HT * VT);
    chk("frame_fs_count", fs_cnt, 1);
    chk("frame_fs_x", fs_x, 0);
    chk("frame_fs_y", fs_y, 0);
    chk("frame_active_count", act_cnt, HA * VA);
    chk("frame_no_err", err_pulses, 0);

    // Single missing hsync on line 1
    wait_gen(0, 1);
    supp_n = 1; err_pulses = 0;
    cyc_n(18);
    chk("miss1_no_early_err", err_pulses, 0);
    cyc();
    chk("miss1_err_pulse", err, 1);
    chk("miss1_err_count", err_count, 1);
    chk("miss1_locked", locked, 1);
    cyc();
    chk("miss1_err_one_cycle", err, 0);
    wait_gen(0, 3);
    chk("miss1_next_line_clean", err_count, 1);
    chk("miss1_still_locked", locked, 1);

    // Four consecutive missing hsyncs drop lock
    supp_n = 4; err_pulses = 0;
    cyc_n(4 * HT);
    chk("loss_err_pulses", err_pulses, 4);
    chk("loss_err_count", err_count, 5);
    chk("loss_locked", locked, 0);
    cyc_n(19);
    chk("loss_reacq_x", x, HSS);
    chk("loss_reacq_locked", locked, 0);
    wait_gen(0, VSS);
    cyc();
    chk("loss_relock", locked, 1);
    chk("loss_relock_y", y, VSS);
    chk("loss_err_count_hold", err_count, 5);

    // hsync 3 cycles early on line 1
    wait_gen(0, 1);
    early_n = 1; err_pulses = 0;
    cyc_n(16);
    chk("early_err_pulse", err, 1);
    chk("early_x_realign", x, HSS);
    chk("early_locked", locked, 1);
    cyc_n(27);
    chk("early_total_pulses", err_pulses, 3);
    chk("early_x_aligned", x, HSS);
    chk("early_err_count", err_count, 8);
    chk("early_still_locked", locked, 1);

    // Bad vsync at line 4
    wait_gen(HT - 1, 3);
    vbad = 1;
    cyc();
    cyc();
    chk("badv_err_pulse", err, 1);
    chk("badv_y_loaded", y, VSS);
    chk("badv_x", x, 0);
    chk("badv_locked", locked, 0);
    chk("badv_err_count", err_count, 9);
    wait_gen(0, 6);
    vbad = 0;
    wait_gen(0, VSS);
    cyc();
    chk("badv_relock", locked, 1);
    chk("badv_err_count_hold", err_count, 9);

    // Toggle hsync every cycle to force saturation
    vsync = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge pixel_clk); #1;
      hsync = ~hsync;
    end
    chk("sat_err_count", err_count, 255);

    // Asynchronous reset mid-stream
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_err_count", err_count, 0);
    chk("arst_x", x, 0);
    chk("arst_y", y, 0);
    chk("arst_locked", locked, 0);
    chk("arst_err", err, 0);
    hsync = 1'b1;
    vsync = 1'b1;
    @(posedge pixel_clk); #3;
    reset_n = 1'b1;
    @(posedge pixel_clk); #1;
    chk("arst_free_x1", x, 1);
    err_pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge pixel_clk); #1;
      err_pulses += int'(err);
    end
    chk("arst_idle_no_err", err_pulses, 0);
    chk("arst_idle_unlocked", locked, 0);
    chk("arst_idle_x", x, 51 % HT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
